branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Fetch-side control-flow sequencer between the branch comparator in execute and the instruction fetch port. Owns the PC register and issues sequential fetch requests (predict-not-taken). It tracks outstanding fetches and redirects on a resolved taken branch, jump or misaligned target. On redirect it flushes younger stages and discards stale fetch responses before restarting fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- TRAP_VEC, 32'h0000_0004, redirect target for a misaligned taken target
- MAX_OUT, 2, max outstanding fetch requests (1..7)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- fetch_pc  out  32  request address
- fetch_valid  out  1  request valid
- fetch_ready  in  1  request accepted when both high
- fetch_resp_valid  in  1  one response returned (in order)
- resp_drop  out  1  discard the response of this cycle
- ex_valid  in  1  execute holds a control-flow instruction
- ex_branch  in  1  conditional branch
- ex_jump  in  1  jal/jalr
- ex_taken  in  1  branch comparator result
- ex_target  in  32  resolved target
- flush  out  1  squash all stages younger than execute
- misalign  out  1  pulse: taken target not word-aligned
- perf_branches  out  32  conditional branches resolved
- perf_taken  out  32  redirects taken

## Operation
- act = ex_jump | (ex_branch & ex_taken); redirect = ex_valid & act & state==RUN.
- States: RUN, DRAIN. Reset -> RUN, pc=RESET_PC, cnt=0.
- RUN:
  - fetch_valid = (cnt < MAX_OUT) & ~redirect & ~rst.
  - On accept, pc <= pc+4, modulo 2^32.
- cnt (3 bits):
  - +1 on accept, −1 on fetch_resp_valid.
  - Both in one cycle: unchanged.
  - Response at cnt==0: protocol error; cnt holds 0.
- Redirect:
  - flush=1 combinationally in the same cycle.
  - pc <= ex_target, or TRAP_VEC when ex_target[1:0]!=0; in that case misalign=1 in the same cycle.
  - Next state DRAIN if cnt' (cnt after this cycle's response) >0, else RUN.
- DRAIN:
  - fetch_valid=0, resp_drop=1.
  - ex_valid ignored; no flush, no redirect.
  - Leave to RUN in the cycle after cnt reaches 0.
- resp_drop = (state==DRAIN) | redirect. A response arriving in the redirect cycle is dropped.
- ex_valid with act=0: no effect except perf counting.
- Reset mid-DRAIN: immediate return to RUN, cnt=0, pc=RESET_PC. Responses still arriving from before reset are not dropped; the fetch unit must be reset together with this block.

## Timing
- Reset values: fetch_pc=RESET_PC, fetch_valid=0 while rst high, flush=0, resp_drop=0, misalign=0, perf counters 0.
- fetch_valid is high in the first cycle after rst deasserts.
- flush, misalign and resp_drop are combinational from ex_* and state; no registered delay.
- Redirect resolved in cycle T:
  - fetch_pc=target at T+1.
  - Earliest fetch_valid is T+1 when cnt'==0.
  - Otherwise one cycle after the last outstanding response.
- fetch_pc and fetch_valid are stable while fetch_valid & ~fetch_ready, except a redirect may withdraw the request.
- Throughput: one request per cycle while cnt<MAX_OUT.

## Configuration
- BRANCH_PERF_EN defined:
  - perf_branches increments on ex_valid & ex_branch in RUN.
  - perf_taken increments on redirect.
  - Both 32-bit, wrap at 2^32.
- Undefined: both outputs tied to 0, no counter flops.

## Test plan
- Reset, fetch_ready=1, responses each cycle one later -> fetch_pc 0,4,8,…; cnt never exceeds 1; resp_drop=0.
- fetch_ready=1, no responses, MAX_OUT=2 -> two requests (0,4), then fetch_valid=0 until a response.
- cnt=2, ex_valid & ex_branch & ex_taken, ex_target=0x100 -> flush=1 that cycle; DRAIN with resp_drop=1 for both responses; fetch_pc=0x100 valid the cycle after the second response.
- ex_jump=1, ex_target=0x102 -> misalign=1, flush=1, next fetch_pc=TRAP_VEC=0x4.
- Redirect with cnt=1 and fetch_resp_valid in the same cycle -> response dropped; RUN retained; fetch_pc=target valid at T+1.
- With BRANCH_PERF_EN: 3 branches (2 taken) plus 1 jump -> perf_branches=3, perf_taken=3. Without the macro -> both 0.

Source files
------------

// File: rtl/branch_redirect_ctrl_if.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl_if
//
// Bundles the fetch-port handshake, the execute-stage control-flow inputs and
// the flush/misalign/performance outputs of branch_redirect_ctrl.
//
// Signals:
//   fetch_pc          32  request address                 (ctrl -> fetch)
//   fetch_valid        1  request valid                   (ctrl -> fetch)
//   fetch_ready        1  request accepted when both high (fetch -> ctrl)
//   fetch_resp_valid   1  one in-order response returned  (fetch -> ctrl)
//   resp_drop          1  discard this cycle's response   (ctrl -> fetch)
//   ex_valid           1  execute holds a control-flow op (ex -> ctrl)
//   ex_branch          1  conditional branch              (ex -> ctrl)
//   ex_jump            1  jal/jalr                        (ex -> ctrl)
//   ex_taken           1  branch comparator result        (ex -> ctrl)
//   ex_target         32  resolved target                 (ex -> ctrl)
//   flush              1  squash stages younger than ex   (ctrl -> pipe)
//   misalign           1  taken target not word-aligned   (ctrl -> pipe)
//   perf_branches     32  conditional branches resolved   (ctrl -> perf)
//   perf_taken        32  redirects taken                 (ctrl -> perf)
//
// Modports: master = the redirect controller, slave = fetch/execute side.
// ---------------------------------------------------------------------------
interface branch_redirect_ctrl_if;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        fetch_resp_valid;
    logic        resp_drop;
    logic        ex_valid;
    logic        ex_branch;
    logic        ex_jump;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        flush;
    logic        misalign;
    logic [31:0] perf_branches;
    logic [31:0] perf_taken;

    modport master (
        output fetch_pc, fetch_valid, resp_drop, flush, misalign,
               perf_branches, perf_taken,
        input  fetch_ready, fetch_resp_valid, ex_valid, ex_branch, ex_jump,
               ex_taken, ex_target
    );

    modport slave (
        input  fetch_pc, fetch_valid, resp_drop, flush, misalign,
               perf_branches, perf_taken,
        output fetch_ready, fetch_resp_valid, ex_valid, ex_branch, ex_jump,
               ex_taken, ex_target
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl
//
// Fetch-side control-flow sequencer. Owns the PC, issues sequential fetch
// requests (predict-not-taken), tracks outstanding fetches, and redirects on
// a resolved taken branch or jump. A misaligned taken target redirects to
// TRAP_VEC instead. After a redirect with fetches still in flight, the block
// drains (drops) their stale responses before fetching from the new PC.
//
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   bus  branch_redirect_ctrl_if.master (fetch handshake, execute inputs,
//        flush/misalign pulses, performance counters)
//
// Parameters: RESET_PC, TRAP_VEC, MAX_OUT (1..7 outstanding requests).
//
// Optional feature macro: BRANCH_PERF_EN -- when defined, perf_branches and
// perf_taken are live 32-bit wrapping counters; otherwise both read 0.
// ---------------------------------------------------------------------------
module branch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0004,
    parameter int          MAX_OUT  = 2
) (
    input logic                   clk,
    input logic                   rst,
    branch_redirect_ctrl_if.master bus
);
    localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [2:0]  cnt;

    logic        act;
    logic        redirect;
    logic        target_misaligned;
    logic        fetch_valid;
    logic        accept;
    logic [2:0]  cnt_next;

    always_comb begin
        act               = bus.ex_jump | (bus.ex_branch & bus.ex_taken);
        // Gated by rst so the pulses read 0 during reset regardless of state.
        redirect          = bus.ex_valid & act & (state == RUN) & ~rst;
        target_misaligned = (bus.ex_target[1:0] != 2'b00);
        // A redirect withdraws any request offered in the same cycle.
        fetch_valid       = (state == RUN) & (cnt < MAX_CNT) & ~redirect & ~rst;
        accept            = fetch_valid & bus.fetch_ready;

        // Accept and response together cancel out; a response with nothing
        // outstanding is a protocol error and must not wrap the counter.
        cnt_next = cnt;
        if (accept && !bus.fetch_resp_valid) begin
            cnt_next = cnt + 3'd1;
        end else if (!accept && bus.fetch_resp_valid && cnt != 3'd0) begin
            cnt_next = cnt - 3'd1;
        end
    end

    assign bus.fetch_pc    = pc;
    assign bus.fetch_valid = fetch_valid;
    assign bus.flush       = redirect;
    assign bus.misalign    = redirect & target_misaligned;
    // The response arriving in the redirect cycle itself is already stale.
    assign bus.resp_drop   = ~rst & ((state == DRAIN) | redirect);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC;
            cnt   <= 3'd0;
        end else begin
            cnt <= cnt_next;
            case (state)
                RUN: begin
                    if (redirect) begin
                        pc    <= target_misaligned ? TRAP_VEC : bus.ex_target;
                        // Only drain if fetches are still in flight after
                        // this cycle's response has been counted.
                        state <= (cnt_next != 3'd0) ? DRAIN : RUN;
                    end else if (accept) begin
                        pc <= pc + 32'd4;
                    end
                end
                DRAIN: begin
                    // Execute is ignored here; only stale responses matter.
                    if (cnt_next == 3'd0) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef BRANCH_PERF_EN
    logic [31:0] perf_branches_q;
    logic [31:0] perf_taken_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches_q <= 32'd0;
            perf_taken_q    <= 32'd0;
        end else begin
            if (bus.ex_valid && bus.ex_branch && state == RUN) begin
                perf_branches_q <= perf_branches_q + 32'd1;
            end
            if (redirect) begin
                perf_taken_q <= perf_taken_q + 32'd1;
            end
        end
    end

    assign bus.perf_branches = perf_branches_q;
    assign bus.perf_taken    = perf_taken_q;
`else
    assign bus.perf_branches = 32'd0;
    assign bus.perf_taken    = 32'd0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_redirect_ctrl
//
// Directed scenarios plus a randomized run of branch_redirect_ctrl. The
// reference model tracks in-flight fetches as a queue of "stale" flags: a
// redirect marks everything still in flight as stale, and the controller is
// draining exactly while stale fetches remain outstanding.
// ---------------------------------------------------------------------------
module tb_branch_redirect_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0004;
    localparam int          MAX_OUT  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;

    branch_redirect_ctrl_if bus ();

    branch_redirect_ctrl #(
        .RESET_PC (RESET_PC),
        .TRAP_VEC (TRAP_VEC),
        .MAX_OUT  (MAX_OUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          mq[$];            // one entry per in-flight fetch, 1 = stale
    logic [31:0] m_pc  = RESET_PC;
    logic [31:0] m_pb  = 32'd0;
    logic [31:0] m_pt  = 32'd0;

    function automatic bit m_draining();
        bit s = 1'b0;
        foreach (mq[i]) if (mq[i]) s = 1'b1;
        return s;
    endfunction

    function automatic bit m_redirect();
        return !rst && bus.ex_valid &&
               (bus.ex_jump || (bus.ex_branch && bus.ex_taken)) && !m_draining();
    endfunction

    function automatic bit m_fetch_valid();
        return !rst && !m_draining() && (mq.size() < MAX_OUT) && !m_redirect();
    endfunction

    function automatic bit m_resp_drop();
        return !rst && (m_draining() || m_redirect());
    endfunction

    function automatic bit m_misalign();
        return m_redirect() && (bus.ex_target[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] m_perf(input logic [31:0] v);
`ifdef BRANCH_PERF_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    always @(posedge clk) begin : ref_model
        bit draining, redir, acc;
        if (rst) begin
            mq.delete();
            m_pc = RESET_PC;
            m_pb = 32'd0;
            m_pt = 32'd0;
        end else begin
            draining = m_draining();
            redir    = m_redirect();
            acc      = m_fetch_valid() && bus.fetch_ready;
            if (bus.ex_valid && bus.ex_branch && !draining) m_pb = m_pb + 32'd1;
            if (redir) m_pt = m_pt + 32'd1;
            if (bus.fetch_resp_valid && mq.size() > 0) void'(mq.pop_front());
            if (redir) begin
                foreach (mq[i]) mq[i] = 1'b1;
                m_pc = (bus.ex_target[1:0] != 2'b00) ? TRAP_VEC : bus.ex_target;
            end
            if (acc) begin
                mq.push_back(1'b0);
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit rdy, input bit resp, input bit ev, input bit br,
                       input bit jp, input bit tk, input logic [31:0] tgt);
        bus.fetch_ready      = rdy;
        bus.fetch_resp_valid = resp;
        bus.ex_valid         = ev;
        bus.ex_branch        = br;
        bus.ex_jump          = jp;
        bus.ex_taken         = tk;
        bus.ex_target        = tgt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 32'h0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        drv(1, 0, 0, 0, 0, 0, 32'h0);
        next_cycle();
        #3;
        n_cmp++; if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_valid got %b want 0", bus.fetch_valid); end
        n_cmp++; if (bus.fetch_pc !== RESET_PC) begin n_fail++; $display("FAIL reset_fetch_pc got %h want %h", bus.fetch_pc, RESET_PC); end
        n_cmp++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b want 0", bus.flush); end
        n_cmp++; if (bus.resp_drop !== 1'b0) begin n_fail++; $display("FAIL reset_resp_drop got %b want 0", bus.resp_drop); end
        n_cmp++; if (bus.misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %b want 0", bus.misalign); end
        n_cmp++; if (bus.perf_branches !== 32'd0 || bus.perf_taken !== 32'd0) begin n_fail++; $display("FAIL reset_perf got %h/%h want 0/0", bus.perf_branches, bus.perf_taken); end
        next_cycle();
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 32'h0);
        #3;
        n_cmp++; if (bus.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid_after_reset got %b want 1", bus.fetch_valid); end
        n_cmp++; if (bus.fetch_pc !== RESET_PC) begin n_fail++; $display("FAIL first_pc_after_reset got %h want %h", bus.fetch_pc, RESET_PC); end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drv(1, (i > 0), 0, 0, 0, 0, 32'h0);
            #3;
            n_cmp++; if (bus.fetch_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc[%0d] got %h want %h", i, bus.fetch_pc, 32'(4 * i)); end
            n_cmp++; if (bus.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d] got %b want 1", i, bus.fetch_valid); end
            n_cmp++; if (bus.resp_drop !== 1'b0) begin n_fail++; $display("FAIL seq_resp_drop[%0d] got %b want 0", i, bus.resp_drop); end
            next_cycle();
        end
    endtask

    task automatic test_max_out();
        do_reset();
        // Stray response with nothing outstanding must not corrupt the count.
        drv(0, 1, 0, 0, 0, 0, 32'h0);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            drv(1, 0, 0, 0, 0, 0, 32'h0);
            #3;
            n_cmp++; if (bus.fetch_valid !== (i < 2)) begin n_fail++; $display("FAIL maxout_valid[%0d] got %b want %b", i, bus.fetch_valid, (i < 2)); end
            n_cmp++; if (bus.fetch_pc !== 32'(4 * ((i < 2) ? i : 2))) begin n_fail++; $display("FAIL maxout_pc[%0d] got %h", i, bus.fetch_pc); end
            next_cycle();
        end
        drv(1, 1, 0, 0, 0, 0, 32'h0);
        #3;
        n_cmp++; if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL maxout_resp_cycle_valid got %b want 0", bus.fetch_valid); end
        next_cycle();
        drv(1, 0, 0, 0, 0, 0, 32'h0);
        #3;
        n_cmp++; if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 32'h8) begin n_fail++; $display("FAIL maxout_resume got v=%b pc=%h want v=1 pc=8", bus.fetch_valid, bus.fetch_pc); end
    endtask

    task automatic test_branch_drain();
        do_reset();
        drv(1, 0, 0, 0, 0, 0, 32'h0);
        next_cycle();
        next_cycle();
        // cnt == 2: taken branch
        drv(1, 0, 1, 1, 0, 1, 32'h100);
        #3;
        n_cmp++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL drain_flush got %b want 1", bus.flush); end
        n_cmp++; if (bus.resp_drop !== 1'b1) begin n_fail++; $display("FAIL drain_redirect_drop got %b want 1", bus.resp_drop); end
        n_cmp++; if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL drain_redirect_valid got %b want 0", bus.fetch_valid); end
        n_cmp++; if (bus.misalign !== 1'b0) begin n_fail++; $display("FAIL drain_misalign got %b want 0", bus.misalign); end
        next_cycle();
        // DRAIN: a jump here must be ignored
        drv(1, 1, 1, 0, 1, 0, 32'h200);
        #3;
        n_cmp++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL drain_ignore_flush got %b want 0", bus.flush); end
        n_cmp++; if (bus.resp_drop !== 1'b1 || bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL drain_resp1 got drop=%b v=%b want 1/0", bus.resp_drop, bus.fetch_valid); end
        n_cmp++; if (bus.fetch_pc !== 32'h100) begin n_fail++; $display("FAIL drain_pc got %h want 100", bus.fetch_pc); end
        next_cycle();
        drv(1, 1, 0, 0, 0, 0, 32'h0);
        #3;
        n_cmp++; if (bus.resp_drop !== 1'b1 || bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL drain_resp2 got drop=%b v=%b want 1/0", bus.resp_drop, bus.fetch_valid); end
        next_cycle();
        drv(1, 0, 0, 0, 0, 0, 32'h0);
        #3;
        n_cmp++; if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 32'h100 || bus.resp_drop !== 1'b0) begin n_fail++; $display("FAIL drain_restart got v=%b pc=%h drop=%b want 1/100/0", bus.fetch_valid, bus.fetch_pc, bus.resp_drop); end
    endtask

    task automatic test_misalign();
        do_reset();
        drv(0, 0, 1, 0, 1, 0, 32'h102);
        #3;
        n_cmp++; if (bus.misalign !== 1'b1 || bus.flush !== 1'b1) begin n_fail++; $display("FAIL misalign_pulse got mis=%b flush=%b want 1/1", bus.misalign, bus.flush); end
        next_cycle();
        drv(0, 0, 0, 0, 0, 0, 32'h0);
        #3;
        n_cmp++; if (bus.fetch_pc !== TRAP_VEC || bus.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL misalign_trap got pc=%h v=%b want %h/1", bus.fetch_pc, bus.fetch_valid, TRAP_VEC); end
        n_cmp++; if (bus.misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_clear got %b want 0", bus.misalign); end
    endtask

    task automatic test_redirect_resp();
        do_reset();
        drv(1, 0, 0, 0, 0, 0, 32'h0);
        next_cycle();
        drv(1, 1, 1, 1, 0, 1, 32'h40);
        #3;
        n_cmp++; if (bus.resp_drop !== 1'b1 || bus.flush !== 1'b1) begin n_fail++; $display("FAIL rr_drop got drop=%b flush=%b want 1/1", bus.resp_drop, bus.flush); end
        next_cycle();
        drv(1, 0, 0, 0, 0, 0, 32'h0);
        #3;
        n_cmp++; if (bus.fetch_pc !== 32'h40 || bus.fetch_valid !== 1'b1 || bus.resp_drop !== 1'b0) begin n_fail++; $display("FAIL rr_restart got pc=%h v=%b drop=%b want 40/1/0", bus.fetch_pc, bus.fetch_valid, bus.resp_drop); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        drv(1, 0, 0, 0, 0, 0, 32'h0);
        next_cycle();
        next_cycle();
        drv(0, 0, 1, 0, 1, 0, 32'h300);
        next_cycle();
        rst = 1'b1;
        drv(0, 1, 0, 0, 0, 0, 32'h0);
        #3;
        n_cmp++; if (bus.resp_drop !== 1'b0) begin n_fail++; $display("FAIL rstdrain_drop got %b want 0", bus.resp_drop); end
        next_cycle();
        rst = 1'b0;
        drv(0, 1, 0, 0, 0, 0, 32'h0);
        #3;
        n_cmp++; if (bus.fetch_pc !== RESET_PC || bus.fetch_valid !== 1'b1 || bus.resp_drop !== 1'b0) begin n_fail++; $display("FAIL rstdrain_run got pc=%h v=%b drop=%b want %h/1/0", bus.fetch_pc, bus.fetch_valid, bus.resp_drop, RESET_PC); end
    endtask

    task automatic test_perf();
        logic [31:0] want;
        do_reset();
        drv(0, 0, 1, 1, 0, 1, 32'h10); next_cycle();   // taken branch
        drv(0, 0, 1, 1, 0, 0, 32'h14); next_cycle();   // not-taken branch
        drv(0, 0, 0, 1, 0, 1, 32'h18); next_cycle();   // not valid: ignored
        drv(0, 0, 1, 1, 0, 1, 32'h20); next_cycle();   // taken branch
        drv(0, 0, 1, 0, 1, 0, 32'h30); next_cycle();   // jump
        drv(0, 0, 0, 0, 0, 0, 32'h0);
        #3;
        want = m_perf(32'd3);
        n_cmp++; if (bus.perf_branches !== want) begin n_fail++; $display("FAIL perf_branches got %0d want %0d", bus.perf_branches, want); end
        n_cmp++; if (bus.perf_taken !== want) begin n_fail++; $display("FAIL perf_taken got %0d want %0d", bus.perf_taken, want); end
        n_cmp++; if (bus.fetch_pc !== 32'h30) begin n_fail++; $display("FAIL perf_pc got %h want 30", bus.fetch_pc); end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        bit          br;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            tgt = $urandom;
            if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
            br = ($urandom_range(1) == 1);
            drv(($urandom_range(3) != 0),
                (mq.size() > 0) && ($urandom_range(2) != 0),
                ($urandom_range(3) == 0), br,
                !br && ($urandom_range(2) == 0),
                ($urandom_range(1) == 1), tgt);
            #3;
            n_cmp++; if (bus.fetch_pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d] got %h want %h", i, bus.fetch_pc, m_pc); end
            n_cmp++; if (bus.fetch_valid !== m_fetch_valid()) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b want %b", i, bus.fetch_valid, m_fetch_valid()); end
            n_cmp++; if (bus.flush !== m_redirect()) begin n_fail++; $display("FAIL rnd_flush[%0d] got %b want %b", i, bus.flush, m_redirect()); end
            n_cmp++; if (bus.misalign !== m_misalign()) begin n_fail++; $display("FAIL rnd_misalign[%0d] got %b want %b", i, bus.misalign, m_misalign()); end
            n_cmp++; if (bus.resp_drop !== m_resp_drop()) begin n_fail++; $display("FAIL rnd_resp_drop[%0d] got %b want %b", i, bus.resp_drop, m_resp_drop()); end
            n_cmp++; if (bus.perf_branches !== m_perf(m_pb) || bus.perf_taken !== m_perf(m_pt)) begin n_fail++; $display("FAIL rnd_perf[%0d] got %0d/%0d want %0d/%0d", i, bus.perf_branches, bus.perf_taken, m_perf(m_pb), m_perf(m_pt)); end
            next_cycle();
        end
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 0, 32'h0);
        test_reset();
        test_sequential();
        test_max_out();
        test_branch_drain();
        test_misalign();
        test_redirect_resp();
        test_reset_mid_drain();
        test_perf();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
